binary_morph_3x3: RTL and testbench
===================================

Name: binary_morph_3x3

Overview:
- Downstream consumer of the three-line interlaced binary pixel buffer.
- Receives one 3-row column of 1-bit pixels per accepted cycle: rows y-1, y and y+1 at column x.
- Slides a 3x3 window across each row and applies a selectable binary morphology operator: pass, erode, dilate or majority.
- Emits one filtered pixel per input pixel, tagged with its linear frame address, for the downstream frame BRAM write port.

Parameters:
- WIDTH, 320, pixels per row.
- HEIGHT, 240, rows per frame.
- ADDR_W, 17, width of out_addr; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_col is valid this cycle.
- in_ready  output  1  block accepts in_col this cycle; a transfer occurs when in_valid && in_ready.
- in_sof  input  1  qualified by a transfer; marks column 0 of row 0.
- in_col  input  3  [2]=row y-1, [1]=row y, [0]=row y+1 at the current column.
- mode  input  2  0=pass center, 1=erode (AND of 9), 2=dilate (OR of 9), 3=majority (popcount >= 5).
- out_valid  output  1  pixel_out/out_addr valid; single-cycle pulse per pixel.
- pixel_out  output  1  filtered pixel.
- out_addr  output  ADDR_W  y*WIDTH + x of the center pixel.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, pixel_out=0, out_addr=0.
  - Internal x=0, y=0, window registers=0, latched mode=0.
  - State=ACCEPT.
- Reset mid-row discards the partial row. The first transfer after reset is treated as x=0, y=0 whether or not in_sof is set.
- Window registers:
  - w_l holds column x-2; w_c holds column x-1.
  - On each transfer: w_l<=w_c, w_c<=in_col.
- States:
  - ACCEPT: in_ready=1.
    - Transfer at x=0: no output.
    - Transfer at x>=1: compute pixel (x-1, y) from w_l, w_c, in_col. Register it so out_valid=1 on the next cycle.
    - Transfer at x=WIDTH-1: go to FLUSH.
    - Otherwise increment x.
  - FLUSH: exactly one cycle, in_ready=0, in_valid ignored.
    - Compute pixel (WIDTH-1, y) using pad as the right column.
    - Then set x=0, advance y (wrap HEIGHT-1 -> 0) and return to ACCEPT.
- Per row: WIDTH+1 cycles minimum and exactly WIDTH outputs. Latency is 1 cycle from the transfer of column x+1 (or the FLUSH cycle) to out_valid for pixel x.
- Padding applies to out-of-frame neighbours: left column at x=0, right column at x=WIDTH-1, bit[2] at y=0, bit[0] at y=HEIGHT-1.
  - Pad value = 1 for erode and 0 for dilate, so borders are neutral.
  - For majority the pad value is 0.
  - For pass, padding is irrelevant.
- Majority uses a 4-bit popcount of the 9 window bits.
- mode is latched only on a transfer with in_sof=1 (or on reset, to 0) and is stable for the frame. Changes mid-frame take effect at the next sof.
- in_sof on a transfer:
  - Forces x=0, y=0 for that column.
  - Discards any partial row: no FLUSH and no outputs for the abandoned row.
  - Clears w_l/w_c before the shift.
  - An output already registered from the previous cycle still appears.
- out_addr is generated by an incrementing counter (no multiplier). It resets to 0 at sof and wraps to 0 after WIDTH*HEIGHT-1.
- in_valid low in ACCEPT stalls the block with no state change. out_valid=0 on every cycle without a pending result.

Test Plan:
- WIDTH=8, HEIGHT=4, mode=0: stream all-ones frame with in_valid held high -> 32 out_valid pulses, pixel_out=1, out_addr 0..31 in order, in_ready low on exactly 4 cycles (after each x=7).
- WIDTH=8, HEIGHT=4, mode=1: solid 1 frame -> all 32 outputs 1 (padding neutral). Single 0 at center row (y=1, x=3) -> zeros at addresses 2,3,4 of rows 0,1,2 (addr 2-4, 10-12, 18-20), all others 1.
- mode=2: single 1 at (x=0, y=0) -> ones only at addr 0,1,8,9; row-3 outputs all 0.
- mode=3: window with exactly 4 ones -> 0; window with exactly 5 ones -> 1. mode toggled mid-frame -> no change until next in_sof.
- in_valid toggled 50% random -> output stream identical to unthrottled run. in_sof asserted at x=5 of row 2 -> no output for (7,2); next out_addr=0.
- reset asserted mid-row for one cycle -> next cycle out_valid=0, in_ready=1. The following transfer is treated as (0,0); first output is out_addr=0.

Source files
------------

// File: rtl/binary_morph_3x3.sv
// binary_morph_3x3: 3x3 binary morphology (pass/erode/dilate/majority) over a streamed 3-row column input
// clk, reset                    : system clock, synchronous active-high reset
// in_valid, in_ready            : column handshake, transfer when both high
// in_sof                        : marks column 0 of row 0
// in_col                        : [2]=row y-1, [1]=row y, [0]=row y+1 at column x
// mode                          : 0 pass, 1 erode, 2 dilate, 3 majority; latched at sof
// out_valid, pixel_out, out_addr: filtered pixel with its linear frame address
module binary_morph_3x3 #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sof,
   input  logic [2:0]        in_col,
   input  logic [1:0]        mode,
   output logic              out_valid,
   output logic              pixel_out,
   output logic [ADDR_W-1:0] out_addr
);
   localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [0:0] ACCEPT = 1'b0;
   localparam logic [0:0] FLUSH  = 1'b1;
   localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
   localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] AMAX = ADDR_W'(WIDTH * HEIGHT - 1);
   // window bit positions of the top and bottom rows across the three columns
   localparam logic [8:0] TOP = 9'b100100100;
   localparam logic [8:0] BOT = 9'b001001001;
   logic [0:0]        r_state;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic [2:0]        r_wl, r_wc;
   logic [1:0]        r_mode;
   logic [ADDR_W-1:0] r_cnt, r_addr;
   logic              r_valid, r_pix;
   logic              w_flush, w_xfer, w_pad, w_emit, w_res;
   logic [XW-1:0]     w_x;
   logic [2:0]        w_l, w_r;
   logic [8:0]        w_raw, w_msk, w_win;
   logic [3:0]        w_pop;
   assign w_flush   = r_state == FLUSH;
   assign in_ready  = !w_flush;
   assign w_xfer    = in_valid && !w_flush;
   assign w_pad     = r_mode == 2'd1;
   assign w_emit    = w_flush || (w_xfer && !in_sof && r_x != '0);
   assign w_x       = in_sof ? '0 : r_x;
   // left neighbour of pixel 0 and right neighbour of the last pixel lie outside the frame
   assign w_l       = (!w_flush && r_x == XW'(1)) ? {3{w_pad}} : r_wl;
   assign w_r       = w_flush ? {3{w_pad}} : in_col;
   assign w_raw     = {w_l, r_wc, w_r};
   assign w_msk     = (r_y == '0 ? TOP : 9'd0) | (r_y == YMAX ? BOT : 9'd0);
   assign w_win     = (w_raw & ~w_msk) | ({9{w_pad}} & w_msk);
   assign out_valid = r_valid;
   assign pixel_out = r_pix;
   assign out_addr  = r_addr;
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < 9; i++) w_pop = w_pop + {3'b000, w_win[i]};
      w_res = r_mode == 2'd0 ? w_win[4] : r_mode == 2'd1 ? &w_win : r_mode == 2'd2 ? |w_win : w_pop >= 4'd5;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ACCEPT;
         r_x     <= '0;
         r_y     <= '0;
         r_wl    <= '0;
         r_wc    <= '0;
         r_mode  <= '0;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_pix   <= 1'b0;
      end else begin
         r_valid <= w_emit;
         if (w_emit) begin
            r_pix  <= w_res;
            r_addr <= r_cnt;
            r_cnt  <= r_cnt == AMAX ? '0 : r_cnt + 1'b1;
         end
         if (w_flush) begin
            r_state <= ACCEPT;
            r_x     <= '0;
            r_y     <= r_y == YMAX ? '0 : r_y + 1'b1;
         end else if (w_xfer) begin
            r_wl    <= in_sof ? '0 : r_wc;
            r_wc    <= in_col;
            r_state <= w_x == XMAX ? FLUSH : ACCEPT;
            r_x     <= w_x == XMAX ? w_x : w_x + 1'b1;
            if (in_sof) begin
               r_mode <= mode;
               r_y    <= '0;
               r_cnt  <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_binary_morph_3x3.sv
// tb_binary_morph_3x3: randomized scoreboard bench for binary_morph_3x3 against a frame-level model
module tb_binary_morph_3x3;
   localparam int W = 8, H = 4, AW = 17;
   logic          clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
   logic [2:0]    in_col = '0;
   logic [1:0]    mode = '0;
   logic          in_ready, out_valid, pixel_out;
   logic [AW-1:0] out_addr;
   int            n_chk = 0, n_pass = 0, rl_cnt = 0;
   bit            img[H][W];
   int            q[$];
   always #5 clk = ~clk;
   binary_morph_3x3 #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_col(in_col), .mode(mode), .out_valid(out_valid), .pixel_out(pixel_out), .out_addr(out_addr)
   );
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   always @(negedge clk) begin
      int e;
      if (!in_ready) rl_cnt++;
      if (out_valid) begin
         if (q.size() == 0) chk("unexpected_out", int'(out_addr), -1);
         else begin
            e = q.pop_front();
            chk("addr", int'(out_addr), e >> 1);
            chk("pix", int'(pixel_out), e & 1);
         end
      end
   end
   function automatic bit ref_pix(input int x, input int y, input int m);
      int c = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            int xx = x + dx;
            int yy = y + dy;
            c += (xx < 0 || xx >= W || yy < 0 || yy >= H) ? int'(m == 1) : int'(img[yy][xx]);
         end
      case (m)
         0: return img[y][x];
         1: return c == 9;
         2: return c > 0;
         default: return c >= 5;
      endcase
   endfunction
   task automatic xfer(input logic [2:0] col, input bit sof, input bit thr);
      int n = 0;
      if (thr) while ($urandom_range(1) == 1) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_col = col;
      in_sof = sof;
      while (!in_ready && n < 4) begin @(negedge clk); n++; end
      if (!in_ready) chk("ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
   endtask
   task automatic frame(input int m, input int ncols, input bit thr, input bit sof);
      int start = rl_cnt, k = 0;
      logic [2:0] col;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (y * W + (x == W - 1 ? x : x + 1) < ncols) q.push_back(((y * W + x) << 1) | int'(ref_pix(x, y, m)));
      mode = 2'(m);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            if (k < ncols) begin
               col[2] = (y > 0) ? img[y-1][x] : 1'($urandom_range(1));
               col[1] = img[y][x];
               col[0] = (y < H - 1) ? img[y+1][x] : 1'($urandom_range(1));
               xfer(col, sof && k == 0, thr);
               if (k == 0) mode = 2'($urandom_range(3));
               k++;
            end
      repeat (4) @(negedge clk);
      chk("drain", q.size(), 0);
      if (ncols == W * H) chk("ready_low", rl_cnt - start, H);
   endtask
   task automatic fill(input int kind);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = kind == 1 ? 1'b1 : kind == 0 ? 1'b0 : 1'($urandom_range(1));
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_pix", int'(pixel_out), 0);
      chk("rst_addr", int'(out_addr), 0);
      reset = 1'b0;
      fill(1);
      frame(0, W * H, 1'b0, 1'b1);
      frame(1, W * H, 1'b0, 1'b1);
      img[1][3] = 1'b0;
      frame(1, W * H, 1'b0, 1'b1);
      fill(0);
      img[0][0] = 1'b1;
      frame(2, W * H, 1'b0, 1'b1);
      fill(2);
      frame(3, W * H, 1'b0, 1'b1);
      frame(3, W * H, 1'b1, 1'b1);
      repeat (8) begin
         fill(2);
         frame($urandom_range(3), W * H, 1'b1, 1'b1);
      end
      fill(2);
      frame(3, 2 * W + 5, 1'b0, 1'b1);
      fill(2);
      frame(2, W * H, 1'b0, 1'b1);
      fill(2);
      frame(1, 11, 1'b0, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_ready", int'(in_ready), 1);
      chk("mid_rst_addr", int'(out_addr), 0);
      reset = 1'b0;
      fill(2);
      frame(0, W * H, 1'b1, 1'b0);
      fill(2);
      frame(3, W * H, 1'b1, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
